alu_uadd_seq: RTL

Multi-cycle, multi-precision unsigned adder sequencer for the SISD ALU. It adds two SIZE*WORDS-bit operands one SIZE-bit slice per clock, least-significant slice first, and chains the carry between slices in a register. This trades latency for area: a single SIZE-bit add slice replaces a full-width ripple chain. It sits between the instruction decode/issue stage and the register writeback, and uses a start/done handshake.

---
 rtl/alu_uadd_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_uadd_seq.sv
// Multi-precision unsigned adder: one SIZE-bit slice per clock, LSB slice first, carry chained in a register.
// Optional build macro ALU_UADD_SEQ_OVF_EN adds a registered signed-overflow output o_overflow.
module alu_uadd_seq #(
    parameter int SIZE  = 8,
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [SIZE*WORDS-1:0] i_s1,
    input  logic [SIZE*WORDS-1:0] i_s2,
    input  logic                  i_carry,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SIZE*WORDS-1:0] o_result,
    output logic                  o_carry
`ifdef ALU_UADD_SEQ_OVF_EN
   ,output logic                  o_overflow
`endif
);

    localparam int W     = SIZE * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             creg;

    logic [SIZE-1:0]  a_slice;
    logic [SIZE-1:0]  b_slice;
    logic [SIZE:0]    slice_full;
    logic [W-1:0]     sum_next;
    logic             last_slice;
    int               slice_lsb;

    // One slice of the add; sum_next is the working sum with this cycle's slice merged in.
    always_comb begin
        slice_lsb  = int'(idx) * SIZE;
        a_slice    = a_reg[slice_lsb +: SIZE];
        b_slice    = b_reg[slice_lsb +: SIZE];
        slice_full = {1'b0, a_slice} + {1'b0, b_slice} + (SIZE+1)'(creg);
        sum_next   = sum_reg;
        sum_next[slice_lsb +: SIZE] = slice_full[SIZE-1:0];
        last_slice = (idx == LAST_IDX);
    end

`ifdef ALU_UADD_SEQ_OVF_EN
    logic ovf_next;

    // Carry into the MSB is recovered from the MSB operand and sum bits of the final slice.
    always_comb begin
        ovf_next = (a_slice[SIZE-1] ^ b_slice[SIZE-1] ^ slice_full[SIZE-1]) ^ slice_full[SIZE];
    end
`endif

    // Results are published on the edge entering DONE so o_done and o_result line up.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            creg     <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_carry  <= 1'b0;
`ifdef ALU_UADD_SEQ_OVF_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_reg   <= i_s1;
                        b_reg   <= i_s2;
                        creg    <= i_carry;
                        sum_reg <= '0;
                        idx     <= '0;
                        o_busy  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        idx    <= '0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        sum_reg <= sum_next;
                        creg    <= slice_full[SIZE];
                        if (last_slice) begin
                            o_done   <= 1'b1;
                            o_result <= sum_next;
                            o_carry  <= slice_full[SIZE];
`ifdef ALU_UADD_SEQ_OVF_EN
                            o_overflow <= ovf_next;
`endif
                            state    <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    idx    <= '0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
